prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader that writes a program image into the CPU's 16×8 memory. The CPU fetches instructions from that memory through MAR/DR; this block is the writer on the same memory port. It accepts a framed byte stream over a valid/ready handshake, writes each payload byte to consecutive addresses from 0, and verifies a checksum. It holds the CPU in reset while loading and releases it only after a good frame.

## Interface
Parameters:
- HDR, 8'hA5, frame header byte
- DEPTH, 16, memory depth in words; maximum payload length
- AW, 4, memory address width

Ports:
- clk  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; arms a load (ignored unless in IDLE, DONE or ERR)
- in_valid  in  1  byte present on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte this cycle
- mem_we  out  1  memory write strobe, one cycle per payload byte
- mem_addr  out  AW  write address
- mem_wdata  out  8  write data
- cpu_hold  out  1  keeps CPU in reset (OR'd into CPU reset by the top level)
- busy  out  1  load in progress
- done  out  1  sticky: last frame loaded and checksum matched
- err  out  1  sticky: last frame rejected

## Operation
- A byte is accepted when in_valid && in_ready on a rising clk edge. in_ready = 1 only in S_HDR, S_CNT, S_DATA and S_CSUM.
- Frame format: HDR, N (1..DEPTH), N payload bytes, C. C = sum of the N payload bytes mod 256.
- States:
  - IDLE: start → S_HDR, which clears done and err and sets cpu_hold = 1.
  - S_HDR: byte == HDR → S_CNT. Any other byte is discarded and the state stays S_HDR (resync).
  - S_CNT: 1 ≤ N ≤ DEPTH → latch N, clear addr counter and sum, go to S_DATA. N = 0 or N > DEPTH → ERR.
  - S_DATA: each accepted byte triggers a write to addr, sum += byte (8-bit wrap), addr++. After the Nth byte → S_CSUM.
  - S_CSUM: byte == sum → DONE. Otherwise → ERR.
  - DONE: done = 1, cpu_hold = 0. start → S_HDR.
  - ERR: err = 1, cpu_hold stays 1 so a partial image never runs. start → S_HDR.
- busy = 1 in S_HDR through S_CSUM.
- The addr counter is AW+1 bits internally, so N = DEPTH does not alias to 0. mem_addr is its low AW bits.
- Memory already written before an error is not rolled back.
- start in S_HDR..S_CSUM is ignored. There is no abort other than RESET.

## Timing
- Reset (async, RESET low): state IDLE. in_ready, mem_we, busy, done, err, cpu_hold = 0. mem_addr = 0, mem_wdata = 0.
- start at edge k → in_ready = 1 and cpu_hold = 1 after edge k.
- Writes are registered. A payload byte accepted at edge k drives mem_we = 1 with its addr/data for exactly the cycle following edge k. The memory captures on edge k+1.
- Back-to-back payload bytes, one per cycle, produce one mem_we per cycle at consecutive addresses with no bubbles.
- in_ready has no combinational path from in_valid. in_valid may drop between bytes; idle cycles are allowed anywhere in the frame.
- Checksum accepted at edge k: done/err and the cpu_hold release are visible after edge k. The last mem_we (from edge k−1 or earlier) has already completed.
- RESET asserted mid-frame: immediate return to IDLE with cpu_hold = 0; any in-flight mem_we is dropped.
- start and an accepted byte in the same cycle in DONE/ERR: start wins; the byte is not accepted because in_ready = 0 in DONE/ERR.

## Test plan
- Good frame A5 03 11 22 33 66, one byte per cycle → writes [0]=11, [1]=22, [2]=33 on three consecutive cycles; done = 1, err = 0, cpu_hold falls the cycle after 66 is accepted.
- Leading garbage 00 FF A5 01 7E 7E → garbage discarded; single write [0]=7E; done = 1.
- Full depth: A5 10, bytes 01..10, checksum 88 → 16 writes to addresses 0..F with no wrap to 0; done = 1. Then a second frame with N = 11 → err = 1 straight from S_CNT, no writes.
- Bad checksum A5 02 80 80 01 (expected 00) → two writes occur, then err = 1 and cpu_hold stays 1. start → S_HDR, err clears.
- Gapped in_valid (random idle cycles) on frame A5 02 F0 0F FF → identical writes and done = 1. N = 0 frame (A5 00) → err = 1.
- RESET pulsed low after the second payload byte of a 4-byte frame → all outputs 0 asynchronously, no further mem_we; start and a new good frame complete normally.

Source files
------------

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream handshake plus memory write port of the program loader
interface prog_loader_if #(parameter int AW = 4);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  modport master (output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader writing a program image and holding the CPU until a good checksum
module prog_loader #(
  parameter logic [7:0] HDR   = 8'hA5,
  parameter int         DEPTH = 16,
  parameter int         AW    = 4
) (
  input  logic           clk,
  input  logic           RESET,
  input  logic           start,
  prog_loader_if.slave   bus,
  output logic           cpu_hold,
  output logic           busy,
  output logic           done,
  output logic           err
);
  typedef enum logic [2:0] {IDLE, S_HDR, S_CNT, S_DATA, S_CSUM, DONE, ERR} state_t;
  localparam logic [7:0] MAXN = 8'(DEPTH);
  state_t      state, nxt;
  logic [AW:0] cnt, addr, addr_n;
  logic [7:0]  sum;
  logic        acc;
  // addr is one bit wider than mem_addr so a full-depth frame ends at DEPTH, not 0
  assign addr_n = addr + 1'b1;
  assign acc    = bus.in_valid && bus.in_ready;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: nxt = start ? S_HDR : state;
      S_HDR:  nxt = (acc && bus.in_data == HDR) ? S_CNT : state;
      S_CNT:  nxt = !acc ? state : (bus.in_data != 8'd0 && bus.in_data <= MAXN) ? S_DATA : ERR;
      S_DATA: nxt = (acc && addr_n == cnt) ? S_CSUM : state;
      S_CSUM: nxt = !acc ? state : (bus.in_data == sum) ? DONE : ERR;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      cnt           <= '0;
      addr          <= '0;
      sum           <= '0;
    end else begin
      state        <= nxt;
      bus.in_ready <= nxt inside {S_HDR, S_CNT, S_DATA, S_CSUM};
      busy         <= nxt inside {S_HDR, S_CNT, S_DATA, S_CSUM};
      cpu_hold     <= !(nxt inside {IDLE, DONE});
      done         <= nxt == DONE;
      err          <= nxt == ERR;
      bus.mem_we   <= acc && state == S_DATA;
      if (acc && state == S_CNT) begin
        cnt  <= bus.in_data[AW:0];
        addr <= '0;
        sum  <= '0;
      end
      if (acc && state == S_DATA) begin
        addr          <= addr_n;
        sum           <= sum + bus.in_data;
        bus.mem_addr  <= addr[AW-1:0];
        bus.mem_wdata <= bus.in_data;
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frame scenarios with hand-computed write logs and status flags
module tb_prog_loader;
  logic clk = 1'b0, RESET = 1'b1, start = 1'b0;
  logic cpu_hold, busy, done, err;
  int tests = 0, fails = 0, cyc = 0;
  logic [3:0] wa[$];
  logic [7:0] wd[$];
  int         wc[$];

  prog_loader_if #(.AW(4)) bus();
  prog_loader #(.HDR(8'hA5), .DEPTH(16), .AW(4)) dut (
    .clk(clk), .RESET(RESET), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.mem_we === 1'b1) begin
    wa.push_back(bus.mem_addr);
    wd.push_back(bus.mem_wdata);
    wc.push_back(cyc);
  end

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete();
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    tests++;
    if (t >= 100) begin fails++; $display("FAIL send_timeout byte=%h in_ready=%b required 1", b, bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic test_reset();
    #3 RESET = 1'b0;
    repeat (2) @(posedge clk);
    #1 tests++;
    if ({bus.in_ready, bus.mem_we, busy, done, err, cpu_hold, bus.mem_addr, bus.mem_wdata} !== 18'd0) begin
      fails++; $display("FAIL reset_outputs got=%b required all 0",
        {bus.in_ready, bus.mem_we, busy, done, err, cpu_hold, bus.mem_addr, bus.mem_wdata});
    end
    @(negedge clk) RESET = 1'b1;
  endtask

  task automatic test_good_frame();
    logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
    clear_log();
    do_start();
    tests++;
    if ({bus.in_ready, cpu_hold, busy} !== 3'b111) begin
      fails++; $display("FAIL start_arm ready/hold/busy=%b required 111", {bus.in_ready, cpu_hold, busy});
    end
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h66);
    tests++;
    if ({done, err, cpu_hold, busy} !== 4'b1000) begin
      fails++; $display("FAIL good_status done/err/hold/busy=%b required 1000", {done, err, cpu_hold, busy});
    end
    tests++;
    if (wa.size() != 3) begin fails++; $display("FAIL good_count got=%0d required 3", wa.size()); end
    else for (int i = 0; i < 3; i++) begin
      tests++;
      if (wa[i] !== 4'(i) || wd[i] !== exp[i] || wc[i] != wc[0] + i) begin
        fails++; $display("FAIL good_write%0d got=[%h]=%h cyc+%0d required [%h]=%h cyc+%0d",
          i, wa[i], wd[i], wc[i] - wc[0], 4'(i), exp[i], i);
      end
    end
  endtask

  task automatic test_garbage();
    clear_log();
    do_start();
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL restart_clears_done got=%b required 0", done); end
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h01); send(8'h7E); send(8'h7E);
    tests++;
    if (wa.size() != 1 || wa[0] !== 4'h0 || wd[0] !== 8'h7E) begin
      fails++; $display("FAIL garbage_write count=%0d required 1 of [0]=7e", wa.size());
    end
    tests++;
    if ({done, err} !== 2'b10) begin fails++; $display("FAIL garbage_status done/err=%b required 10", {done, err}); end
  endtask

  task automatic test_full_depth();
    clear_log();
    do_start();
    send(8'hA5); send(8'h10);
    for (int i = 1; i <= 16; i++) send(8'(i));
    send(8'h88);
    tests++;
    if (wa.size() != 16) begin fails++; $display("FAIL full_count got=%0d required 16", wa.size()); end
    else for (int i = 0; i < 16; i++) begin
      tests++;
      if (wa[i] !== 4'(i) || wd[i] !== 8'(i + 1)) begin
        fails++; $display("FAIL full_write%0d got=[%h]=%h required [%h]=%h", i, wa[i], wd[i], 4'(i), 8'(i + 1));
      end
    end
    tests++;
    if ({done, err, cpu_hold} !== 3'b100) begin fails++; $display("FAIL full_status done/err/hold=%b required 100", {done, err, cpu_hold}); end
    do_start();
    clear_log();
    send(8'hA5); send(8'h11);
    tests++;
    if ({done, err, cpu_hold, busy, bus.in_ready} !== 5'b01100) begin
      fails++; $display("FAIL oversize_status done/err/hold/busy/ready=%b required 01100", {done, err, cpu_hold, busy, bus.in_ready});
    end
    repeat (2) @(posedge clk);
    tests++;
    if (wa.size() != 0) begin fails++; $display("FAIL oversize_writes got=%0d required 0", wa.size()); end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    do_start();
    send(8'hA5); send(8'h02); send(8'h80); send(8'h80); send(8'h01);
    tests++;
    if (wa.size() != 2 || wd[0] !== 8'h80 || wd[1] !== 8'h80 || wa[1] !== 4'h1) begin
      fails++; $display("FAIL badsum_writes count=%0d required 2 of [0]=80 [1]=80", wa.size());
    end
    tests++;
    if ({done, err, cpu_hold} !== 3'b011) begin fails++; $display("FAIL badsum_status done/err/hold=%b required 011", {done, err, cpu_hold}); end
    do_start();
    tests++;
    if ({err, busy, bus.in_ready, cpu_hold} !== 4'b0111) begin
      fails++; $display("FAIL restart_from_err err/busy/ready/hold=%b required 0111", {err, busy, bus.in_ready, cpu_hold});
    end
  endtask

  task automatic test_gapped();
    logic [7:0] f [5] = '{8'hA5, 8'h02, 8'hF0, 8'h0F, 8'hFF};
    clear_log();
    do_start();
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(f[i]);
    end
    tests++;
    if (wa.size() != 2 || wa[0] !== 4'h0 || wd[0] !== 8'hF0 || wa[1] !== 4'h1 || wd[1] !== 8'h0F) begin
      fails++; $display("FAIL gapped_writes count=%0d required 2 of [0]=f0 [1]=0f", wa.size());
    end
    tests++;
    if ({done, err, cpu_hold} !== 3'b100) begin fails++; $display("FAIL gapped_status done/err/hold=%b required 100", {done, err, cpu_hold}); end
    do_start();
    send(8'hA5); send(8'h00);
    tests++;
    if ({done, err, cpu_hold} !== 3'b011) begin fails++; $display("FAIL zero_len done/err/hold=%b required 011", {done, err, cpu_hold}); end
  endtask

  task automatic test_reset_midframe();
    do_start();
    clear_log();
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
    RESET = 1'b0;
    #1 tests++;
    if ({bus.in_ready, bus.mem_we, busy, done, err, cpu_hold, bus.mem_addr, bus.mem_wdata} !== 18'd0) begin
      fails++; $display("FAIL midreset_outputs got=%b required all 0",
        {bus.in_ready, bus.mem_we, busy, done, err, cpu_hold, bus.mem_addr, bus.mem_wdata});
    end
    repeat (3) @(posedge clk);
    tests++;
    if (wa.size() != 1) begin fails++; $display("FAIL midreset_writes got=%0d required 1", wa.size()); end
    @(negedge clk) RESET = 1'b1;
    clear_log();
    do_start();
    send(8'hA5); send(8'h01); send(8'h42); send(8'h42);
    tests++;
    if (wa.size() != 1 || wa[0] !== 4'h0 || wd[0] !== 8'h42 || done !== 1'b1 || cpu_hold !== 1'b0) begin
      fails++; $display("FAIL post_reset_frame count=%0d done=%b hold=%b required 1 write [0]=42 done=1 hold=0",
        wa.size(), done, cpu_hold);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_good_frame();
    test_garbage();
    test_full_depth();
    test_bad_checksum();
    test_gapped();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
